// File: rtl/mul_red_sched.sv
// Round-robin issue scheduler sharing one mul_Red_0 multiplier between two requesters.
// Tracks in-flight ops with a tag pipe and steers results into credit-protected response FIFOs.
module mul_red_sched #(
    parameter int MUL_LAT    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_intt,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [97:0] req_data,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [47:0] rsp_data,
    output logic [23:0] mul_A,
    output logic [23:0] mul_w,
    output logic [1:0]  mul_sel_a,
    output logic        mul_red_mode,
    input  logic [23:0] mul_result,
    output logic        busy
);
    localparam int DATA_W = 24;
    localparam int REQ_W  = 2 * DATA_W + 1;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;
    localparam int TAGS   = MUL_LAT + 2;

    typedef struct packed {
        logic vld;
        logic id;
        logic mode;
    } tag_t;

    logic              intt_mode;
    logic              ptr;
    logic              pipe_busy;
    logic              mode_pending;
    logic              any_gnt;
    logic              gnt_id;
    logic [1:0]        elig;
    logic [1:0]        grant;
    logic [1:0]        retire;
    logic [1:0]        pop;
    logic [REQ_W-1:0]  req_sel;
    tag_t              tag_in;
    tag_t              tail;
    tag_t              tag_p [TAGS];
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] a_p1;
    logic [DATA_W-1:0] w_p0;
    logic [CW-1:0]     inflight [2];
    logic [CW-1:0]     count    [2];
    logic [CW:0]       occ      [2];
    logic [PW-1:0]     wr_ptr   [2];
    logic [PW-1:0]     rd_ptr   [2];
    logic [DATA_W-1:0] mem      [2][FIFO_DEPTH];

    always_comb begin
        pipe_busy = 1'b0;
        for (int k = 0; k < TAGS; k++) begin
            pipe_busy = pipe_busy | tag_p[k].vld;
        end
    end

    // A pending cfg_intt change blocks issue until the tag pipe is empty and the mode flips.
    assign mode_pending = (cfg_intt != intt_mode);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            occ[i]  = (CW + 1)'(count[i]) + (CW + 1)'(inflight[i]);
            elig[i] = rst && req_valid[i] && !mode_pending && (occ[i] < (CW + 1)'(FIFO_DEPTH));
        end
    end

    always_comb begin
        grant  = '0;
        gnt_id = ptr;
        if (elig[ptr]) begin
            grant[ptr] = 1'b1;
            gnt_id     = ptr;
        end else if (elig[!ptr]) begin
            grant[!ptr] = 1'b1;
            gnt_id      = !ptr;
        end
    end

    assign any_gnt   = |grant;
    assign req_ready = grant;
    assign req_sel   = gnt_id ? req_data[2*REQ_W-1:REQ_W] : req_data[REQ_W-1:0];

    always_comb begin
        tag_in = '0;
        if (any_gnt) begin
            tag_in.vld  = 1'b1;
            tag_in.id   = gnt_id;
            tag_in.mode = req_sel[REQ_W-1];
        end
    end

    // Stage p0: operand issue; p1 delays A by one cycle for INTT sessions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_p0      <= '0;
            a_p1      <= '0;
            w_p0      <= '0;
            ptr       <= 1'b0;
            intt_mode <= 1'b0;
        end else begin
            a_p0 <= any_gnt ? req_sel[2*DATA_W-1:DATA_W] : '0;
            w_p0 <= any_gnt ? req_sel[DATA_W-1:0] : '0;
            a_p1 <= a_p0;
            if (any_gnt) begin
                ptr <= !gnt_id;
            end
            if (!pipe_busy) begin
                intt_mode <= cfg_intt;
            end
        end
    end

    // Tag pipe: tag_p[k] is visible k+1 cycles after the grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAGS; k++) begin
                tag_p[k] <= '0;
            end
        end else begin
            tag_p[0] <= tag_in;
            for (int k = 1; k < TAGS - 1; k++) begin
                tag_p[k] <= tag_p[k-1];
            end
            // The extra stage only carries tags in INTT; otherwise a retired tag could retire twice.
            tag_p[TAGS-1] <= intt_mode ? tag_p[TAGS-2] : '0;
        end
    end

    assign mul_A        = intt_mode ? a_p1 : a_p0;
    assign mul_w        = w_p0;
    assign mul_sel_a    = intt_mode ? 2'b10 : 2'b00;
    assign tail         = intt_mode ? tag_p[TAGS-1] : tag_p[TAGS-2];
    assign mul_red_mode = tail.vld & tail.mode;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            retire[i]    = tail.vld && (tail.id == 1'(i));
            rsp_valid[i] = (count[i] != '0);
            pop[i]       = rsp_ready[i] && rsp_valid[i];
        end
    end

    // Result stage: counters net grant/retire/pop in one update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                inflight[i] <= '0;
                count[i]    <= '0;
                wr_ptr[i]   <= '0;
                rd_ptr[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                inflight[i] <= inflight[i] + CW'(grant[i]) - CW'(retire[i]);
                count[i]    <= count[i] + CW'(retire[i]) - CW'(pop[i]);
                wr_ptr[i]   <= wr_ptr[i] + PW'(retire[i]);
                rd_ptr[i]   <= rd_ptr[i] + PW'(pop[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (retire[i]) begin
                mem[i][wr_ptr[i]] <= mul_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst && retire[i] && !pop[i]) begin
                assert (count[i] != CW'(FIFO_DEPTH));
            end
        end
    end

    always_comb begin
        rsp_data = '0;
        for (int i = 0; i < 2; i++) begin
            if (rsp_valid[i]) begin
                rsp_data[DATA_W*i +: DATA_W] = mem[i][rd_ptr[i]];
            end
        end
    end

    assign busy = pipe_busy | (|rsp_valid);

endmodule

// File: tb/tb_mul_red_sched.sv
// Directed scoreboard bench for mul_red_sched with a behavioural stand-in for mul_Red_0.
// The stand-in multiplies 12-bit lanes; D_redu results are XOR-marked so mode misalignment shows up in data.
module tb_mul_red_sched;
    localparam int MUL_LAT    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam logic [23:0] DMASK = 24'hA5A5A5;

    typedef struct packed {
        int   due;
        logic mode;
    } mev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_intt = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [97:0] req_data = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [47:0] rsp_data;
    logic [23:0] mul_A;
    logic [23:0] mul_w;
    logic [1:0]  mul_sel_a;
    logic        mul_red_mode;
    logic [23:0] mul_result;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int gcnt [2];
    int npop [2];
    int gseq [$];
    int glast;
    logic [23:0] sb0 [$];
    logic [23:0] sb1 [$];
    mev_t mq [$];
    logic mode_alt = 1'b0;
    logic alt_mode = 1'b1;

    logic [23:0] mpipe [MUL_LAT];
    logic [23:0] w_d = '0;

    mul_red_sched #(.MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .cfg_intt(cfg_intt),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mul_A(mul_A), .mul_w(mul_w), .mul_sel_a(mul_sel_a),
        .mul_red_mode(mul_red_mode), .mul_result(mul_result), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] mulred(input logic [23:0] a, input logic [23:0] w);
        logic [23:0] hi;
        logic [23:0] lo;
        hi = 24'(a[23:12]) * 24'(w[23:12]);
        lo = 24'(a[11:0]) * 24'(w[11:0]);
        return {hi[11:0], lo[11:0]};
    endfunction

    initial begin
        for (int k = 0; k < MUL_LAT; k++) mpipe[k] = '0;
    end

    always @(posedge clk) begin
        w_d      <= mul_w;
        mpipe[0] <= mulred(mul_A, (mul_sel_a == 2'b10) ? w_d : mul_w);
        for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_result = mpipe[MUL_LAT-1] ^ (mul_red_mode ? DMASK : 24'h0);

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on grant, pop on response, mode check at the due result cycle
    always @(negedge clk) begin
        logic [48:0] r;
        logic [23:0] e;
        if (!rst) begin
            sb0.delete();
            sb1.delete();
            mq.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    npop[i]++;
                    if (i == 0) begin
                        chk("rsp0_expected_pending", 48'(sb0.size() != 0), 48'(1));
                        if (sb0.size() != 0) begin
                            e = sb0.pop_front();
                            chk("rsp0_data", 48'(rsp_data[23:0]), 48'(e));
                        end
                    end else begin
                        chk("rsp1_expected_pending", 48'(sb1.size() != 0), 48'(1));
                        if (sb1.size() != 0) begin
                            e = sb1.pop_front();
                            chk("rsp1_data", 48'(rsp_data[47:24]), 48'(e));
                        end
                    end
                end
            end
            if (mq.size() != 0 && mq[0].due == cyc) begin
                chk("result_cycle_mode", 48'(mul_red_mode), 48'(mq[0].mode));
                void'(mq.pop_front());
            end
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    r = req_data[49*i +: 49];
                    e = mulred(r[47:24], r[23:0]) ^ (r[48] ? DMASK : 24'h0);
                    if (i == 0) sb0.push_back(e);
                    else        sb1.push_back(e);
                    mq.push_back('{due: cyc + 1 + MUL_LAT + (cfg_intt ? 1 : 0), mode: r[48]});
                end
            end
        end
    end

    task automatic set_req(input int i, input logic m, input logic [23:0] a, input logic [23:0] w);
        req_data[49*i +: 49] = {m, a, w};
    endtask

    task automatic new_req(input int i);
        logic m;
        m = mode_alt ? alt_mode : 1'($urandom_range(0, 1));
        if (mode_alt) alt_mode = ~alt_mode;
        set_req(i, m, 24'($urandom), 24'($urandom));
    endtask

    task automatic run(input int n, input logic [1:0] vmask);
        logic [1:0] g;
        req_valid = vmask;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            g = req_ready;
            for (int i = 0; i < 2; i++) begin
                if (g[i]) begin
                    gcnt[i]++;
                    gseq.push_back(i);
                    glast = cyc;
                end
            end
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (g[i]) new_req(i);
            end
        end
    endtask

    task automatic wait_grant(input int i, output int g);
        g = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                g = cyc;
                break;
            end
        end
        chk("grant_seen", 48'(g >= 0), 48'(1));
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("drain_busy", 48'(busy), 48'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        int g;
        int p0;
        int p1;
        logic [23:0] a_exp;
        gcnt = '{0, 0};
        npop = '{0, 0};

        // Reset with both requesters asserting
        #2 rst = 1'b0;
        req_valid = 2'b11;
        set_req(0, 1'b0, 24'h111111, 24'h222222);
        set_req(1, 1'b1, 24'h333333, 24'h444444);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 48'(req_ready), 48'(0));
        chk("rst_rsp_valid", 48'(rsp_valid), 48'(0));
        chk("rst_rsp_data", rsp_data, 48'(0));
        chk("rst_mul_A", 48'(mul_A), 48'(0));
        chk("rst_mul_w", 48'(mul_w), 48'(0));
        chk("rst_sel_a", 48'(mul_sel_a), 48'(0));
        chk("rst_red_mode", 48'(mul_red_mode), 48'(0));
        chk("rst_busy", 48'(busy), 48'(0));
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst = 1'b1;
        rsp_ready = 2'b11;

        // 1: single K op and its latency
        set_req(0, 1'b0, {12'd5, 12'd7}, {12'd3, 12'd2});
        req_valid = 2'b01;
        wait_grant(0, g);
        @(negedge clk);
        chk("t1_issue_A", 48'(mul_A), 48'h005007);
        chk("t1_issue_w", 48'(mul_w), 48'h003002);
        chk("t1_sel_a", 48'(mul_sel_a), 48'(0));
        repeat (MUL_LAT) @(negedge clk);
        chk("t1_cycle", 48'(cyc), 48'(g + 1 + MUL_LAT));
        chk("t1_not_yet_valid", 48'(rsp_valid[0]), 48'(0));
        chk("t1_mul_result", 48'(mul_result), 48'h00F00E);
        @(negedge clk);
        chk("t1_rsp_valid", 48'(rsp_valid[0]), 48'(1));
        chk("t1_rsp_data", 48'(rsp_data[23:0]), 48'h00F00E);
        @(posedge clk); #1;
        drain();

        // 2: contention
        gseq.delete();
        gcnt = '{0, 0};
        p0 = npop[0];
        p1 = npop[1];
        new_req(0);
        new_req(1);
        run(8, 2'b11);
        req_valid = 2'b00;
        chk("t2_grant_count", 48'(gseq.size()), 48'(8));
        for (int k = 1; k < gseq.size(); k++) begin
            chk("t2_alternate", 48'(gseq[k] != gseq[k-1]), 48'(1));
        end
        chk("t2_gcnt0", 48'(gcnt[0]), 48'(4));
        chk("t2_gcnt1", 48'(gcnt[1]), 48'(4));
        drain();
        chk("t2_rsp0_count", 48'(npop[0] - p0), 48'(4));
        chk("t2_rsp1_count", 48'(npop[1] - p1), 48'(4));

        // 3: backpressure on requester 0
        rsp_ready = 2'b10;
        gcnt = '{0, 0};
        new_req(0);
        new_req(1);
        run(20, 2'b11);
        req_valid = 2'b01;
        chk("t3_req0_grants", 48'(gcnt[0]), 48'(FIFO_DEPTH));
        chk("t3_req1_served", 48'(gcnt[1] > 4), 48'(1));
        @(negedge clk);
        chk("t3_req0_blocked", 48'(req_ready[0]), 48'(0));
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        @(posedge clk); #1;
        rsp_ready = 2'b10;
        gcnt = '{0, 0};
        run(15, 2'b01);
        chk("t3_one_more_grant", 48'(gcnt[0]), 48'(1));
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        drain();

        // 4: mixed modes back-to-back
        mode_alt = 1'b1;
        alt_mode = 1'b1;
        gcnt = '{0, 0};
        new_req(0);
        run(8, 2'b01);
        req_valid = 2'b00;
        mode_alt = 1'b0;
        chk("t4_some_grants", 48'(gcnt[0] >= 4), 48'(1));
        drain();

        // 5: INTT issue order, then a deferred mode change
        cfg_intt = 1'b1;
        set_req(0, 1'b0, 24'h123456, 24'h000ABC);
        req_valid = 2'b01;
        wait_grant(0, g);
        @(negedge clk);
        chk("t5_w_first", 48'(mul_w), 48'h000ABC);
        chk("t5_A_not_yet", 48'(mul_A), 48'(0));
        chk("t5_sel_a", 48'(mul_sel_a), 48'(2'b10));
        @(negedge clk);
        chk("t5_A_second", 48'(mul_A), 48'h123456);
        chk("t5_sel_a_held", 48'(mul_sel_a), 48'(2'b10));
        @(posedge clk); #1;
        drain();
        gcnt = '{0, 0};
        new_req(0);
        run(3, 2'b01);
        chk("t5_intt_burst", 48'(gcnt[0]), 48'(3));
        cfg_intt = 1'b0;
        for (int c = glast + 1; c <= glast + 2 + MUL_LAT; c++) begin
            @(negedge clk);
            chk("t5_stall_pending", 48'(req_ready[0]), 48'(0));
        end
        a_exp = req_data[47:24];
        wait_grant(0, g);
        @(negedge clk);
        chk("t5_normal_sel_a", 48'(mul_sel_a), 48'(0));
        chk("t5_normal_A", 48'(mul_A), 48'(a_exp));
        @(posedge clk); #1;
        drain();

        // 6: reset with ops in flight
        rsp_ready = 2'b00;
        new_req(0);
        new_req(1);
        gcnt = '{0, 0};
        run(3, 2'b11);
        req_valid = 2'b00;
        chk("t6_in_flight", 48'(gcnt[0] + gcnt[1]), 48'(3));
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rsp_valid", 48'(rsp_valid), 48'(0));
        chk("t6_mul_A", 48'(mul_A), 48'(0));
        chk("t6_mul_w", 48'(mul_w), 48'(0));
        chk("t6_red_mode", 48'(mul_red_mode), 48'(0));
        chk("t6_busy", 48'(busy), 48'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        rsp_ready = 2'b11;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk("t6_no_stale_rsp", 48'(rsp_valid), 48'(0));
            chk("t6_idle", 48'(busy), 48'(0));
        end

        chk("end_sb0_empty", 48'(sb0.size()), 48'(0));
        chk("end_sb1_empty", 48'(sb1.size()), 48'(0));
        chk("end_mode_q_empty", 48'(mq.size()), 48'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
